cam_frame_seq: RTL and testbench

//  Frame-capture sequencer for the OV-camera + AL422-type frame FIFO datapath.
//  On a start command it arms the FIFO write side for exactly one camera frame (vsync-delimited, href-gated).
//  It then drives the FIFO read side (rrst/oe/rck), packs bytes into 32-bit words and hands them out on a valid/ready stream.

---
 rtl/cam_frame_seq_if.sv | 38 +++
 rtl/cam_frame_seq.sv | 218 +++++++++++++++++++++
 tb/tb_cam_frame_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_seq_if.sv
// cam_frame_seq_if
//   Groups the FIFO pin bundle and the packed-word stream of the frame
//   sequencer so the sequencer and its neighbours connect through one port.
//   master : the sequencer (drives FIFO control pins and the word stream)
//   slave  : the FIFO / word consumer side (drives fifo_din and pix_ready)
//   Signals:
//     fifo_din     FIFO read data
//     fifo_wrst_n  FIFO write-pointer reset, active-low
//     fifo_we_n    FIFO write enable, active-low
//     fifo_rrst_n  FIFO read-pointer reset, active-low
//     fifo_oe_n    FIFO output enable, active-low
//     fifo_rck     FIFO read clock
//     pix_data     packed word, first byte read in [7:0]
//     pix_valid    pix_data valid, held until pix_ready
//     pix_ready    consumer accepts the word when pix_valid & pix_ready
interface cam_frame_seq_if;
   logic [7:0]  fifo_din;
   logic        fifo_wrst_n;
   logic        fifo_we_n;
   logic        fifo_rrst_n;
   logic        fifo_oe_n;
   logic        fifo_rck;
   logic [31:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (
      input  fifo_din, pix_ready,
      output fifo_wrst_n, fifo_we_n, fifo_rrst_n, fifo_oe_n, fifo_rck,
             pix_data, pix_valid
   );

   modport slave (
      output fifo_din, pix_ready,
      input  fifo_wrst_n, fifo_we_n, fifo_rrst_n, fifo_oe_n, fifo_rck,
             pix_data, pix_valid
   );
endinterface

// File: rtl/cam_frame_seq.sv
// cam_frame_seq
//   Frame-capture sequencer between an OV camera, an AL422-type frame FIFO and
//   the camera peripheral. A start request arms the FIFO write side for exactly
//   one vsync-delimited, href-gated frame, then reads the frame back through
//   rrst/oe/rck, packs bytes LSB-first into 32-bit words and hands them out on
//   a valid/ready stream. All outputs are registered.
//   Ports:
//     clk    system clock
//     rst    synchronous reset, active-low
//     start  1-cycle capture request, only honoured while idle
//     vsync  camera vsync (already synchronised), polarity set by VSYNC_POL
//     href   camera href (already synchronised)
//     bus    FIFO pins and word stream (cam_frame_seq_if.master)
//     busy   high in every state except IDLE
//     done   1-cycle pulse after the last word has been accepted
module cam_frame_seq #(
   parameter int FRAME_BYTES = 614400,
   parameter int CNT_W       = 20,
   parameter int RCK_DIV     = 2,
   parameter int RST_CYC     = 4,
   parameter int VSYNC_POL   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            vsync,
   input  logic            href,
   cam_frame_seq_if.master bus,
   output logic            busy,
   output logic            done
);

   localparam int RCW = $clog2(RST_CYC + 1);
   localparam int DVW = $clog2(RCK_DIV + 1);
   localparam logic             VS_INV    = (VSYNC_POL == 0);
   localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BYTES);

   typedef enum logic [2:0] {
      IDLE, WAIT_VS, WRST, WAIT_FS, CAPTURE, RRST, READ, DONE
   } state_e;

   state_e            state_q, state_d;
   logic              wrst_n_q, wrst_n_d;
   logic              we_n_q, we_n_d;
   logic              rrst_n_q, rrst_n_d;
   logic              oe_n_q, oe_n_d;
   logic              rck_q, rck_d;
   logic [31:0]       pix_data_q, pix_data_d;
   logic [23:0]       shift_q, shift_d;
   logic              pix_valid_q, pix_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [DVW-1:0]    div_cnt_q, div_cnt_d;
   logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;

   logic vs;
   logic tick;
   logic stall;
   logic accept;

   // vsync normalised to its active level; tick marks the end of an rck phase
   assign vs     = vsync ^ VS_INV;
   assign tick   = (div_cnt_q == DVW'(RCK_DIV - 1));
   assign stall  = pix_valid_q & ~bus.pix_ready;
   assign accept = pix_valid_q & bus.pix_ready;

   // Next-state and next-output logic. Bytes are collected in a 3-byte shift
   // register so the presented word stays stable while the consumer stalls;
   // the 4th byte completes the word directly into pix_data.
   always_comb begin
      state_d     = state_q;
      wrst_n_d    = wrst_n_q;
      we_n_d      = we_n_q;
      rrst_n_d    = rrst_n_q;
      oe_n_d      = oe_n_q;
      rck_d       = rck_q;
      pix_data_d  = pix_data_q;
      shift_d     = shift_q;
      pix_valid_d = pix_valid_q;
      byte_cnt_d  = byte_cnt_q;
      div_cnt_d   = div_cnt_q;
      rst_cnt_d   = rst_cnt_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = WAIT_VS;
         end
         WAIT_VS: begin
            if (vs) begin
               state_d   = WRST;
               wrst_n_d  = 1'b0;
               rst_cnt_d = '0;
            end
         end
         WRST: begin
            if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
               wrst_n_d = 1'b1;
               state_d  = WAIT_FS;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         // Entered with vs active, so any inactive vs here is the frame start
         WAIT_FS: begin
            if (!vs) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (vs) begin
               we_n_d    = 1'b1;
               rrst_n_d  = 1'b0;
               oe_n_d    = 1'b0;
               rst_cnt_d = '0;
               state_d   = RRST;
            end else begin
               we_n_d = ~href;
            end
         end
         RRST: begin
            byte_cnt_d = '0;
            div_cnt_d  = '0;
            rck_d      = 1'b0;
            if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
               rrst_n_d = 1'b1;
               state_d  = READ;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         READ: begin
            if (accept) pix_valid_d = 1'b0;
            if (byte_cnt_q == FRAME_END) begin
               if (accept) begin
                  oe_n_d  = 1'b1;
                  rck_d   = 1'b0;
                  state_d = DONE;
               end
            end else if (rck_q) begin
               // Falling rck: the FIFO byte is sampled in this cycle
               if (tick) begin
                  rck_d      = 1'b0;
                  div_cnt_d  = '0;
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  shift_d    = {bus.fifo_din, shift_q[23:8]};
                  if (byte_cnt_q[1:0] == 2'd3) begin
                     pix_data_d  = {bus.fifo_din, shift_q};
                     pix_valid_d = 1'b1;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end else if (!stall) begin
               // Rising rck is held off (rck parks low) while a word is stuck
               if (tick) begin
                  rck_d     = 1'b1;
                  div_cnt_d = '0;
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset; a reset
   // in any state drops the partial word and returns every pin to idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         wrst_n_q    <= 1'b1;
         we_n_q      <= 1'b1;
         rrst_n_q    <= 1'b1;
         oe_n_q      <= 1'b1;
         rck_q       <= 1'b0;
         pix_data_q  <= '0;
         shift_q     <= '0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         byte_cnt_q  <= '0;
         div_cnt_q   <= '0;
         rst_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         wrst_n_q    <= wrst_n_d;
         we_n_q      <= we_n_d;
         rrst_n_q    <= rrst_n_d;
         oe_n_q      <= oe_n_d;
         rck_q       <= rck_d;
         pix_data_q  <= pix_data_d;
         shift_q     <= shift_d;
         pix_valid_q <= pix_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         byte_cnt_q  <= byte_cnt_d;
         div_cnt_q   <= div_cnt_d;
         rst_cnt_q   <= rst_cnt_d;
      end
   end

   assign bus.fifo_wrst_n = wrst_n_q;
   assign bus.fifo_we_n   = we_n_q;
   assign bus.fifo_rrst_n = rrst_n_q;
   assign bus.fifo_oe_n   = oe_n_q;
   assign bus.fifo_rck    = rck_q;
   assign bus.pix_data    = pix_data_q;
   assign bus.pix_valid   = pix_valid_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_cam_frame_seq.sv
// tb_cam_frame_seq
//   Directed bench for cam_frame_seq with FRAME_BYTES=8, RCK_DIV=1, RST_CYC=4.
//   A second instance with VSYNC_POL=0 sees the inverted vsync and must behave
//   identically. A small FIFO model presents 0x11..0x88 on successive rck
//   rising edges.
module tb_cam_frame_seq;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic vsync;
   logic vsyncN;
   logic href;
   logic busy, done, busyN, doneN;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] rdMem [0:7];
   int         rdPtr   = 0;
   logic       rckPrev = 1'b0;

   cam_frame_seq_if bus ();
   cam_frame_seq_if busN ();

   assign vsyncN         = ~vsync;
   assign busN.fifo_din  = bus.fifo_din;
   assign busN.pix_ready = bus.pix_ready;

   cam_frame_seq #(.FRAME_BYTES(8), .CNT_W(20), .RCK_DIV(1), .RST_CYC(4), .VSYNC_POL(1)) dut (
      .clk(clk), .rst(rst), .start(start), .vsync(vsync), .href(href),
      .bus(bus.master), .busy(busy), .done(done)
   );

   cam_frame_seq #(.FRAME_BYTES(8), .CNT_W(20), .RCK_DIV(1), .RST_CYC(4), .VSYNC_POL(0)) dutN (
      .clk(clk), .rst(rst), .start(start), .vsync(vsyncN), .href(href),
      .bus(busN.master), .busy(busyN), .done(doneN)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // FIFO read-side model: read pointer cleared while rrst_n is low, next byte
   // presented shortly after each rck rising edge
   always @(posedge clk) begin
      #1;
      if (!bus.fifo_rrst_n) begin
         rdPtr = 0;
      end else if (bus.fifo_rck && !rckPrev) begin
         bus.fifo_din = rdMem[rdPtr % 8];
         rdPtr++;
      end
      rckPrev = bus.fifo_rck;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Walks one full capture: start, vsync pulse, short href frame, vsync rise.
   // Returns with the DUT one cycle into RRST.
   task automatic armFrame(input bit startMid);
      start = 1'b1; step(); start = 1'b0;
      vsync = 1'b0; href = 1'b0; step();
      vsync = 1'b1; repeat (8) step();
      vsync = 1'b0; repeat (2) step();
      href = 1'b1; step();
      if (startMid) start = 1'b1;
      step();
      start = 1'b0; href = 1'b0; step();
      vsync = 1'b1; step();
      vsync = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
         href  = 1'($urandom_range(0, 1));
         bus.pix_ready = 1'($urandom_range(0, 1));
         step();
      end
      vectors++; if ({bus.fifo_wrst_n, bus.fifo_we_n, bus.fifo_rrst_n, bus.fifo_oe_n} !== 4'b1111) begin
         miscompares++; $display("[TB] FAIL reset_fifo_ctl got %b want 1111", {bus.fifo_wrst_n, bus.fifo_we_n, bus.fifo_rrst_n, bus.fifo_oe_n}); end
      vectors++; if (bus.fifo_rck !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_rck got %b want 0", bus.fifo_rck); end
      vectors++; if ({bus.pix_valid, bus.pix_data} !== 33'd0) begin
         miscompares++; $display("[TB] FAIL reset_pix got %b/%h want 0/00000000", bus.pix_valid, bus.pix_data); end
      vectors++; if ({busy, done} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL reset_busy_done got %b want 00", {busy, done}); end
      rst = 1'b1; start = 1'b0; vsync = 1'b0; href = 1'b0; bus.pix_ready = 1'b1;
      step();
   endtask

   // Write-side arming for both vsync polarities
   task automatic test_capture();
      logic [7:0] hp;
      int wBad = 0, wBadN = 0, weBad = 0, weBadN = 0, rBad = 0, n = 0;
      logic expW;
      hp = 8'b1011_0110;
      start = 1'b1; step(); start = 1'b0;
      vectors++; if ({busy, busyN} !== 2'b11) begin
         miscompares++; $display("[TB] FAIL capture_busy got %b want 11", {busy, busyN}); end
      vsync = 1'b0; step(); step();
      for (int i = 0; i < 8; i++) begin
         vsync = 1'b1; step();
         expW = (i < 4) ? 1'b0 : 1'b1;
         if (bus.fifo_wrst_n !== expW) wBad++;
         if (busN.fifo_wrst_n !== expW) wBadN++;
         if (bus.fifo_we_n !== 1'b1) weBad++;
         if (busN.fifo_we_n !== 1'b1) weBadN++;
      end
      vectors++; if (wBad != 0) begin
         miscompares++; $display("[TB] FAIL capture_wrst_n bad_cycles=%0d want 0", wBad); end
      vectors++; if (wBadN != 0) begin
         miscompares++; $display("[TB] FAIL pol0_wrst_n bad_cycles=%0d want 0", wBadN); end
      vsync = 1'b0; href = 1'b1; step();
      if (bus.fifo_we_n !== 1'b1) weBad++;
      if (busN.fifo_we_n !== 1'b1) weBadN++;
      for (int i = 0; i < 8; i++) begin
         href = hp[i]; step();
         if (bus.fifo_we_n !== ~hp[i]) weBad++;
         if (busN.fifo_we_n !== ~hp[i]) weBadN++;
      end
      vsync = 1'b1; href = 1'b1; step();
      if (bus.fifo_we_n !== 1'b1) weBad++;
      if (busN.fifo_we_n !== 1'b1) weBadN++;
      vectors++; if ({bus.fifo_rrst_n, bus.fifo_oe_n} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL capture_rrst_oe got %b want 00", {bus.fifo_rrst_n, bus.fifo_oe_n}); end
      vsync = 1'b0;
      for (int i = 0; i < 4; i++) begin
         href = ~href; step();
         if (bus.fifo_we_n !== 1'b1) weBad++;
         if (busN.fifo_we_n !== 1'b1) weBadN++;
         if (bus.fifo_rrst_n !== ((i < 3) ? 1'b0 : 1'b1)) rBad++;
      end
      href = 1'b0;
      vectors++; if (weBad != 0) begin
         miscompares++; $display("[TB] FAIL capture_we_n bad_cycles=%0d want 0", weBad); end
      vectors++; if (weBadN != 0) begin
         miscompares++; $display("[TB] FAIL pol0_we_n bad_cycles=%0d want 0", weBadN); end
      vectors++; if (rBad != 0) begin
         miscompares++; $display("[TB] FAIL capture_rrst_n bad_cycles=%0d want 0", rBad); end
      while (busy && n < 200) begin step(); n++; end
      vectors++; if ({busy, busyN} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL capture_drain busy got %b want 00 after %0d cycles", {busy, busyN}, n); end
   endtask

   // Full readback with an always-ready consumer
   task automatic test_read();
      logic [31:0] got [0:3];
      int words = 0, doneCnt = 0, doneOeBad = 0;
      bus.pix_ready = 1'b1;
      armFrame(1'b0);
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.pix_valid) begin
            if (words < 4) got[words] = bus.pix_data;
            words++;
         end
         if (done) begin
            doneCnt++;
            if (bus.fifo_oe_n !== 1'b1 || bus.fifo_rck !== 1'b0) doneOeBad++;
         end
      end
      vectors++; if (words != 2) begin
         miscompares++; $display("[TB] FAIL read_word_count got %0d want 2", words); end
      vectors++; if (words >= 1 && got[0] !== 32'h44332211) begin
         miscompares++; $display("[TB] FAIL read_word0 got %h want 44332211", got[0]); end
      vectors++; if (words >= 2 && got[1] !== 32'h88776655) begin
         miscompares++; $display("[TB] FAIL read_word1 got %h want 88776655", got[1]); end
      vectors++; if (doneCnt != 1) begin
         miscompares++; $display("[TB] FAIL read_done_cycles got %0d want 1", doneCnt); end
      vectors++; if (doneOeBad != 0) begin
         miscompares++; $display("[TB] FAIL read_done_oe_rck bad_cycles=%0d want 0", doneOeBad); end
      vectors++; if ({busy, bus.fifo_oe_n, bus.fifo_rck} !== 3'b010) begin
         miscompares++; $display("[TB] FAIL read_after_done busy/oe_n/rck got %b want 010", {busy, bus.fifo_oe_n, bus.fifo_rck}); end
   endtask

   // Consumer stalls on the first word
   task automatic test_backpressure();
      bit found = 1'b0;
      int stallBad = 0, words = 0, doneCnt = 0;
      logic [31:0] w1 = '0;
      bus.pix_ready = 1'b0;
      armFrame(1'b0);
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (bus.pix_valid) found = 1'b1;
      end
      vectors++; if (!found || bus.pix_data !== 32'h44332211) begin
         miscompares++; $display("[TB] FAIL stall_word0 valid=%b got %h want 44332211", found, bus.pix_data); end
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.fifo_rck !== 1'b0 || bus.pix_valid !== 1'b1 || bus.pix_data !== 32'h44332211) stallBad++;
      end
      vectors++; if (stallBad != 0) begin
         miscompares++; $display("[TB] FAIL stall_hold bad_cycles=%0d want 0", stallBad); end
      bus.pix_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.pix_valid) begin w1 = bus.pix_data; words++; end
         if (done) doneCnt++;
      end
      vectors++; if (words != 1 || w1 !== 32'h88776655) begin
         miscompares++; $display("[TB] FAIL stall_word1 count=%0d got %h want 1/88776655", words, w1); end
      vectors++; if (doneCnt != 1 || busy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL stall_done done_cycles=%0d busy=%b want 1/0", doneCnt, busy); end
   endtask

   // start pulses while busy must not launch another frame
   task automatic test_start_ignored();
      int words = 0, doneCnt = 0;
      bus.pix_ready = 1'b1;
      armFrame(1'b1);
      for (int i = 0; i < 60; i++) begin
         start = (i == 8) ? 1'b1 : 1'b0;
         step();
         if (bus.pix_valid) words++;
         if (done) doneCnt++;
      end
      start = 1'b0;
      vectors++; if (words != 2 || doneCnt != 1) begin
         miscompares++; $display("[TB] FAIL busy_start words=%0d done_cycles=%0d want 2/1", words, doneCnt); end
      vectors++; if (busy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL busy_start_idle busy got %b want 0", busy); end
   endtask

   // Reset in the middle of a readback
   task automatic test_reset_mid_read();
      bus.pix_ready = 1'b1;
      armFrame(1'b0);
      repeat (7) step();
      vectors++; if ({busy, bus.fifo_oe_n} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL midread_pre busy/oe_n got %b want 10", {busy, bus.fifo_oe_n}); end
      rst = 1'b0; step();
      vectors++; if ({busy, bus.fifo_oe_n, bus.pix_valid, bus.fifo_rck, bus.fifo_rrst_n} !== 5'b01001) begin
         miscompares++; $display("[TB] FAIL midread_rst busy/oe_n/valid/rck/rrst_n got %b want 01001", {busy, bus.fifo_oe_n, bus.pix_valid, bus.fifo_rck, bus.fifo_rrst_n}); end
      vectors++; if (bus.pix_data !== 32'h0) begin
         miscompares++; $display("[TB] FAIL midread_data got %h want 00000000", bus.pix_data); end
      rst = 1'b1; repeat (3) step();
      vectors++; if ({busy, done} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL midread_after busy/done got %b want 00", {busy, done}); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rdMem[i] = 8'((i + 1) * 8'h11);
      bus.pix_ready = 1'b1;
      start = 1'b0; vsync = 1'b0; href = 1'b0; rst = 1'b0;
      test_reset();
      test_capture();
      test_read();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
